iob_sync_asym_fifo_w_big: RTL and testbench

- Single-clock FIFO: wide write port, narrow read port; W_DATA_W is an integer multiple RATIO of R_DATA_W.
- Each accepted write word is unpacked into RATIO read words; lowest slice (bits R_DATA_W-1:0) is read first.
- Used where a wide producer (bus word, DMA beat) feeds a narrow consumer (byte stream, serializer).
- Storage is a narrow-word array of 2**ADDR_W read words; flags and level are registered.

---
 rtl/iob_sync_asym_fifo_w_big_if.sv | 25 ++
 rtl/iob_sync_asym_fifo_w_big.sv | 95 +++++++++
 tb/tb_iob_sync_asym_fifo_w_big.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/iob_sync_asym_fifo_w_big_if.sv
// Bundle of write-port, read-port and status signals of the asymmetric FIFO.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface iob_sync_asym_fifo_w_big_if #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4
);
    logic                w_en;
    logic [W_DATA_W-1:0] w_data;
    logic                w_full;
    logic                r_en;
    logic [R_DATA_W-1:0] r_data;
    logic                r_empty;
    logic [ADDR_W:0]     level;

    modport master (
        output w_en, w_data, r_en,
        input  w_full, r_data, r_empty, level
    );

    modport slave (
        input  w_en, w_data, r_en,
        output w_full, r_data, r_empty, level
    );
endinterface

// File: rtl/iob_sync_asym_fifo_w_big.sv
// Single-clock asymmetric FIFO: one wide write word is stored as RATIO narrow
// read words (lowest slice first) and drained one narrow word per read.
// Occupancy is tracked in read words; full/empty come from the level, not from
// pointer comparison, so the whole array is usable.
// Constraints: W_DATA_W = RATIO*R_DATA_W, RATIO a power of two >= 2,
// ADDR_W > log2(RATIO).
module iob_sync_asym_fifo_w_big #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    iob_sync_asym_fifo_w_big_if.slave    bus
);
    localparam int RATIO   = W_DATA_W / R_DATA_W;
    localparam int RATIO_W = $clog2(RATIO);
    localparam int WPTR_W  = ADDR_W - RATIO_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] RATIO_LV     = RATIO[ADDR_W:0];
    localparam logic [ADDR_W:0] FULL_THR_LV  = DEPTH[ADDR_W:0] - RATIO_LV;
    localparam logic [ADDR_W:0] RATIO_M1_LV  = RATIO_LV - 1'b1;

    logic [R_DATA_W-1:0] ram [DEPTH];
    logic [WPTR_W-1:0]   w_ptr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     level_q;
    logic [ADDR_W:0]     level_next;
    logic                w_full_q;
    logic                r_empty_q;
    logic [R_DATA_W-1:0] r_data_q;
    logic                w_acc;
    logic                r_acc;

    // Acceptance uses only the registered flags, so no input reaches an output
    // combinationally and a full FIFO never admits a write in a read cycle.
    assign w_acc = bus.w_en & ~w_full_q;
    assign r_acc = bus.r_en & ~r_empty_q;

    // Next occupancy from the accepted operations of this cycle.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        level_next = level_q;
        unique case ({w_acc, r_acc})
            2'b10:   level_next = level_q + RATIO_LV;
            2'b01:   level_next = level_q - 1'b1;
            2'b11:   level_next = level_q + RATIO_M1_LV;
            default: level_next = level_q;
        endcase
    end

    // Unpack an accepted write word into RATIO consecutive narrow slots.
    // NOTE: the storage array has no reset; contents are discarded logically by
    // clearing the pointers and level, which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (w_acc && !rst) begin
            for (int i = 0; i < RATIO; i++) begin
                ram[{w_ptr, i[RATIO_W-1:0]}] <= bus.w_data[i*R_DATA_W +: R_DATA_W];
            end
        end
    end

    // Pointers, level, registered flags and the read data register.
    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            r_data_q  <= '0;
        end else begin
            if (w_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (r_acc) begin
                r_ptr    <= r_ptr + 1'b1;
                r_data_q <= ram[r_ptr];
            end
            level_q   <= level_next;
            r_empty_q <= (level_next == '0);
            w_full_q  <= (level_next > FULL_THR_LV);
        end
    end

    assign bus.w_full  = w_full_q;
    assign bus.r_empty = r_empty_q;
    assign bus.level   = level_q;
    assign bus.r_data  = r_data_q;

endmodule

// File: tb/tb_iob_sync_asym_fifo_w_big.sv
// Self-checking bench for iob_sync_asym_fifo_w_big (W=32, R=8, ADDR_W=4).
// A byte queue holds the expected read stream; a small occupancy model
// predicts level and flags.
module tb_iob_sync_asym_fifo_w_big;
    localparam int W      = 32;
    localparam int R      = 8;
    localparam int AW     = 4;
    localparam int RATIO  = W / R;
    localparam int DEPTH  = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    iob_sync_asym_fifo_w_big_if #(.W_DATA_W(W), .R_DATA_W(R), .ADDR_W(AW)) bus ();

    iob_sync_asym_fifo_w_big #(.W_DATA_W(W), .R_DATA_W(R), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [R-1:0] sb_q [$];
    int           m_level = 0;
    logic [R-1:0] m_rdata = '0;
    int           n_pass  = 0;
    int           n_total = 0;

    // One clock of stimulus; the model updates and the scoreboard is compared
    // one step after the edge.
    task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
        logic          wa;
        logic          ra;
        logic [AW:0]   exp_level;
        logic          exp_full;
        logic          exp_empty;
        wa = we && (m_level <= DEPTH - RATIO);
        ra = re && (m_level != 0);
        bus.w_en   = we;
        bus.w_data = wd;
        bus.r_en   = re;
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        if (ra) begin
            m_rdata = sb_q.pop_front();
            m_level = m_level - 1;
        end
        if (wa) begin
            for (int i = 0; i < RATIO; i++) sb_q.push_back(wd[i*R +: R]);
            m_level = m_level + RATIO;
        end
        exp_level = m_level[AW:0];
        exp_full  = (m_level > DEPTH - RATIO);
        exp_empty = (m_level == 0);
        n_total++;
        if (bus.r_data !== m_rdata)
            $display("FAIL sb_r_data: got %h expected %h", bus.r_data, m_rdata);
        else n_pass++;
        n_total++;
        if (bus.level !== exp_level)
            $display("FAIL sb_level: got %0d expected %0d", bus.level, exp_level);
        else n_pass++;
        n_total++;
        if ({bus.w_full, bus.r_empty} !== {exp_full, exp_empty})
            $display("FAIL sb_flags: got full=%b empty=%b expected full=%b empty=%b",
                     bus.w_full, bus.r_empty, exp_full, exp_empty);
        else n_pass++;
    endtask

    // Reset with both requests asserted; reset must win.
    task automatic do_reset();
        rst        = 1'b1;
        bus.w_en   = 1'b1;
        bus.w_data = 32'hFFFF_FFFF;
        bus.r_en   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        sb_q.delete();
        m_level = 0;
        m_rdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({bus.r_empty, bus.w_full, bus.level, bus.r_data} !== {1'b1, 1'b0, 5'd0, 8'h00})
            $display("FAIL reset_state: got empty=%b full=%b level=%0d r_data=%h expected 1 0 0 00",
                     bus.r_empty, bus.w_full, bus.level, bus.r_data);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [R-1:0] exp_b [RATIO];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1'b1, 32'h4433_2211, 1'b0);
        n_total++;
        if (bus.level !== 5'd4) $display("FAIL basic_level: got %0d expected 4", bus.level);
        else n_pass++;
        for (int i = 0; i < RATIO; i++) begin
            step(1'b0, '0, 1'b1);
            n_total++;
            if (bus.r_data !== exp_b[i])
                $display("FAIL basic_byte%0d: got %h expected %h", i, bus.r_data, exp_b[i]);
            else n_pass++;
        end
        n_total++;
        if ({bus.level, bus.r_empty} !== {5'd0, 1'b1})
            $display("FAIL basic_drained: got level=%0d empty=%b expected 0 1", bus.level, bus.r_empty);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [W-1:0] wd;
        logic [R-1:0] eb;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < RATIO; i++) wd[i*R +: R] = 8'(8'hA0 + 4*k + i);
            step(1'b1, wd, 1'b0);
        end
        n_total++;
        if ({bus.level, bus.w_full} !== {5'd16, 1'b1})
            $display("FAIL full_level: got level=%0d full=%b expected 16 1", bus.level, bus.w_full);
        else n_pass++;
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        n_total++;
        if (bus.level !== 5'd16) $display("FAIL overflow_level: got %0d expected 16", bus.level);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            eb = 8'(8'hA0 + i);
            n_total++;
            if (bus.r_data !== eb)
                $display("FAIL full_byte%0d: got %h expected %h", i, bus.r_data, eb);
            else n_pass++;
        end
    endtask

    task automatic test_threshold();
        for (int k = 0; k < 4; k++) step(1'b1, 32'h1000_0000 * (k + 1) + 32'h0003_0201, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);
        n_total++;
        if ({bus.level, bus.w_full} !== {5'd13, 1'b1})
            $display("FAIL thr_13: got level=%0d full=%b expected 13 1", bus.level, bus.w_full);
        else n_pass++;
        step(1'b1, 32'h7777_7777, 1'b0);
        n_total++;
        if (bus.level !== 5'd13) $display("FAIL thr_blocked: got %0d expected 13", bus.level);
        else n_pass++;
        step(1'b0, '0, 1'b1);
        n_total++;
        if ({bus.level, bus.w_full} !== {5'd12, 1'b0})
            $display("FAIL thr_12: got level=%0d full=%b expected 12 0", bus.level, bus.w_full);
        else n_pass++;
        step(1'b1, 32'h6655_4433, 1'b1);
        n_total++;
        if ({bus.level, bus.w_full} !== {5'd15, 1'b1})
            $display("FAIL thr_15: got level=%0d full=%b expected 15 1", bus.level, bus.w_full);
        else n_pass++;
        repeat (15) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_underflow();
        step(1'b1, 32'h5A33_2211, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        n_total++;
        if ({bus.level, bus.r_data} !== {5'd0, 8'h5A})
            $display("FAIL underflow: got level=%0d r_data=%h expected 0 5a", bus.level, bus.r_data);
        else n_pass++;
        step(1'b1, 32'h0403_0201, 1'b1);
        n_total++;
        if ({bus.level, bus.r_data} !== {5'd4, 8'h5A})
            $display("FAIL wr_rd_empty: got level=%0d r_data=%h expected 4 5a", bus.level, bus.r_data);
        else n_pass++;
        step(1'b0, '0, 1'b1);
        n_total++;
        if (bus.r_data !== 8'h01) $display("FAIL after_underflow: got %h expected 01", bus.r_data);
        else n_pass++;
        repeat (3) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_stream();
        int written = 0;
        int cycles  = 0;
        logic we;
        logic re;
        while (written < 40 && cycles < 2000) begin
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 3) != 0);
            if (we && m_level <= DEPTH - RATIO) written++;
            step(we, $urandom, re);
            cycles++;
        end
        n_total++;
        if (written != 40) $display("FAIL stream_budget: got %0d words expected 40", written);
        else n_pass++;
        // Leave data in flight, then reset mid-stream.
        while (m_level > DEPTH - RATIO) step(1'b0, '0, 1'b1);
        step(1'b1, 32'hCAFE_F00D, 1'b0);
        do_reset();
        n_total++;
        if ({bus.level, bus.r_empty} !== {5'd0, 1'b1})
            $display("FAIL midrst: got level=%0d empty=%b expected 0 1", bus.level, bus.r_empty);
        else n_pass++;
        step(1'b1, 32'h8877_6655, 1'b0);
        step(1'b1, 32'hCCBB_AA99, 1'b0);
        cycles = 0;
        while (m_level != 0 && cycles < 20) begin
            step(1'b0, '0, 1'b1);
            cycles++;
        end
        step(1'b0, '0, 1'b1);
        n_total++;
        if ({bus.level, bus.r_data} !== {5'd0, 8'hCC})
            $display("FAIL post_rst_drain: got level=%0d r_data=%h expected 0 cc", bus.level, bus.r_data);
        else n_pass++;
    endtask

    initial begin
        bus.w_en   = 1'b0;
        bus.w_data = '0;
        bus.r_en   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_threshold();
        test_underflow();
        test_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
